// File: rtl/zeroheti_pkg.sv
// zeroHETI shared definitions: address map and machine-timer register layout.
package zeroheti_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] last;
    } addr_rule_t;

    typedef struct packed {
        addr_rule_t mtimer;
    } addr_map_t;

    localparam addr_rule_t MtimerAddr = '{base: 32'h0000_2100, last: 32'h0000_2114};
    localparam addr_map_t  AddrMap    = '{mtimer: MtimerAddr};

    localparam logic [31:0] MtimeLoOffs    = 32'h00;
    localparam logic [31:0] MtimeHiOffs    = 32'h04;
    localparam logic [31:0] MtimecmpLoOffs = 32'h08;
    localparam logic [31:0] MtimecmpHiOffs = 32'h0C;
    localparam logic [31:0] MtimerCtrlOffs = 32'h10;
    localparam logic [31:0] MtimerWinSize  = 32'h14;

    localparam int unsigned MtimerPrescW = 8;

    typedef struct packed {
        logic [MtimerPrescW-1:0] presc;
        logic                    en;
    } mtimer_ctrl_t;

    // Byte-enable merge of a 32-bit bus write into an existing register word.
    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zeroheti_mtimer_presc.sv
// Prescaler for the machine timer: emits one tick every PRESC+1 enabled cycles.
module zeroheti_mtimer_presc
    import zeroheti_pkg::*;
#(
    parameter int unsigned PrescW = MtimerPrescW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en,
    input  logic [PrescW-1:0] presc,
    input  logic              clr,
    output logic              tick
);

    logic [PrescW-1:0] cnt_q;
    logic              hit;

    assign hit = (cnt_q == presc);
    // A CTRL write on this edge restarts the count and swallows any pending tick.
    assign tick = en & hit & ~clr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr || !en || hit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PrescW'(1);
        end
    end

endmodule

// File: rtl/zeroheti_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a single-cycle OBI-subset port.
module zeroheti_mtimer
    import zeroheti_pkg::*;
#(
    parameter logic [31:0] BaseAddr = AddrMap.mtimer.base,
    parameter int unsigned PrescW   = MtimerPrescW
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        timer_irq_o
);

    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              en_q, en_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [31:0]       offs;
    logic [31:0]       rd_val;
    logic              addr_err;
    logic              wr;
    logic              ctrl_clr;
    logic              tick;
    logic              rvalid_q, err_q, irq_q;
    logic [31:0]       rdata_q;

    assign gnt_o    = req_i;
    assign offs     = addr_i - BaseAddr;
    // Addresses below the base wrap to large offsets and fall into the error range.
    assign addr_err = (offs >= MtimerWinSize) || (addr_i[1:0] != 2'b00);
    assign wr       = req_i & we_i & ~addr_err;
    assign ctrl_clr = wr & (offs == MtimerCtrlOffs) & (|be_i);

    zeroheti_mtimer_presc #(
        .PrescW (PrescW)
    ) i_presc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (en_q),
        .presc  (presc_q),
        .clr    (ctrl_clr),
        .tick   (tick)
    );

    always_comb begin
        rd_val = '0;
        case (offs)
            MtimeLoOffs:    rd_val = mtime_q[31:0];
            MtimeHiOffs:    rd_val = mtime_q[63:32];
            MtimecmpLoOffs: rd_val = mtimecmp_q[31:0];
            MtimecmpHiOffs: rd_val = mtimecmp_q[63:32];
            MtimerCtrlOffs: begin
                rd_val[0]           = en_q;
                rd_val[8 +: PrescW] = presc_q;
            end
            default: ;
        endcase
    end

    // A write to either mtime half replaces the tick increment for that cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'(tick);
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        presc_d    = presc_q;
        if (wr && (|be_i)) begin
            case (offs)
                MtimeLoOffs:    mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], wdata_i, be_i)};
                MtimeHiOffs:    mtime_d = {be_merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                MtimecmpLoOffs: mtimecmp_d = {mtimecmp_q[63:32], be_merge(mtimecmp_q[31:0], wdata_i, be_i)};
                MtimecmpHiOffs: mtimecmp_d = {be_merge(mtimecmp_q[63:32], wdata_i, be_i), mtimecmp_q[31:0]};
                MtimerCtrlOffs: begin
                    if (be_i[0]) en_d = wdata_i[0];
                    for (int i = 0; i < PrescW; i++) begin
                        if (be_i[(8 + i) >> 3]) presc_d[i] = wdata_i[8 + i];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            presc_q    <= '0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
            irq_q      <= (mtime_d >= mtimecmp_d);
            rvalid_q   <= req_i;
            err_q      <= req_i & addr_err;
            rdata_q    <= (req_i & ~we_i & ~addr_err) ? rd_val : '0;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// Scoreboard bench for zeroheti_mtimer: directed bus traffic with hand-computed responses.
module tb_zeroheti_mtimer;

    localparam logic [31:0] BASE    = 32'h0000_2100;
    localparam logic [31:0] O_LO    = 32'h00;
    localparam logic [31:0] O_HI    = 32'h04;
    localparam logic [31:0] O_CMPLO = 32'h08;
    localparam logic [31:0] O_CMPHI = 32'h0C;
    localparam logic [31:0] O_CTRL  = 32'h10;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [3:0]  be_i    = 4'h0;
    logic [31:0] addr_i  = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        timer_irq_o;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    zeroheti_mtimer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b expected no response", rdata_o, err_o);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, ".rdata"}, 64'(rdata_o), 64'(e.rdata));
                check({e.tag, ".err"},   64'(err_o),   64'(e.err));
            end
        end
    end

    task automatic access(input string tag, input logic w, input logic [31:0] offs,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        exp_q.push_back('{tag, exp_rd, exp_err});
        req_i   = 1'b1;
        we_i    = w;
        addr_i  = BASE + offs;
        be_i    = be;
        wdata_i = wd;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
        be_i  = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] offs, input logic [31:0] exp_rd);
        access(tag, 1'b0, offs, 4'hF, 32'h0, exp_rd, 1'b0);
    endtask

    task automatic wr(input string tag, input logic [31:0] offs, input logic [3:0] be, input logic [31:0] wd);
        access(tag, 1'b1, offs, be, wd, 32'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata",  64'(rdata_o),  64'd0);
        check("rst_err",    64'(err_o),    64'd0);
        check("rst_irq",    64'(timer_irq_o), 64'd0);
        rst_ni = 1'b1;
        idle(1);

        rd("rst_lo",    O_LO,    32'h0);
        rd("rst_hi",    O_HI,    32'h0);
        rd("rst_cmplo", O_CMPLO, 32'hFFFF_FFFF);
        rd("rst_cmphi", O_CMPHI, 32'hFFFF_FFFF);
        rd("rst_ctrl",  O_CTRL,  32'h0);
        check("irq_after_rst_reads", 64'(timer_irq_o), 64'd0);

        // PRESC 3: one tick every 4 cycles.
        wr("ctrl_p3", O_CTRL, 4'hF, 32'h0000_0301);
        idle(40);
        rd("p3_lo_a", O_LO, 32'd10);
        rd("p3_lo_b", O_LO, 32'd10);
        rd("p3_ctrl", O_CTRL, 32'h0000_0301);
        wr("ctrl_off", O_CTRL, 4'hF, 32'h0);
        idle(20);
        rd("frozen_lo", O_LO, 32'd10);
        rd("frozen_hi", O_HI, 32'd0);

        // LO->HI carry.
        wr("lo_fffe", O_LO, 4'hF, 32'hFFFF_FFFE);
        wr("hi_0",    O_HI, 4'hF, 32'h0);
        wr("ctrl_p0", O_CTRL, 4'hF, 32'h0000_0001);
        idle(2);
        rd("carry_lo", O_LO, 32'h0);
        rd("carry_hi", O_HI, 32'h1);
        wr("ctrl_off2", O_CTRL, 4'hF, 32'h0);
        rd("carry_lo4", O_LO, 32'h2);

        // 64-bit wrap from all ones.
        wr("lo_ones", O_LO, 4'hF, 32'hFFFF_FFFF);
        wr("hi_ones", O_HI, 4'hF, 32'hFFFF_FFFF);
        check("irq_all_ones", 64'(timer_irq_o), 64'd1);
        wr("ctrl_p0b", O_CTRL, 4'hF, 32'h0000_0001);
        idle(1);
        check("irq_after_wrap", 64'(timer_irq_o), 64'd0);
        rd("wrap_lo", O_LO, 32'h0);
        rd("wrap_hi", O_HI, 32'h0);
        wr("ctrl_off3", O_CTRL, 4'hF, 32'h0);
        rd("wrap_lo3", O_LO, 32'h2);

        // Compare match at 100.
        wr("cmplo_100", O_CMPLO, 4'hF, 32'd100);
        wr("cmphi_0",   O_CMPHI, 4'hF, 32'h0);
        wr("lo_95",     O_LO,    4'hF, 32'd95);
        wr("ctrl_p0c",  O_CTRL,  4'hF, 32'h0000_0001);
        idle(4);
        check("irq_at_99", 64'(timer_irq_o), 64'd0);
        idle(1);
        check("irq_at_100", 64'(timer_irq_o), 64'd1);
        wr("cmphi_1", O_CMPHI, 4'hF, 32'h1);
        check("irq_cleared", 64'(timer_irq_o), 64'd0);
        wr("ctrl_off4", O_CTRL, 4'hF, 32'h0);
        rd("irq_lo", O_LO, 32'd101);

        // Partial write coinciding with a tick.
        wr("ctrl_p0d", O_CTRL, 4'hF, 32'h0000_0001);
        wr("lo_byte1", O_LO, 4'b0010, 32'h0000_AB00);
        wr("ctrl_off5", O_CTRL, 4'hF, 32'h0);
        rd("byte1_lo", O_LO, 32'h0000_AB65);
        rd("byte1_hi", O_HI, 32'h0);

        // Error accesses have no side effects.
        access("err_rd14",  1'b0, 32'h14,        4'hF, 32'h0,         32'h0, 1'b1);
        access("err_wr02",  1'b1, 32'h02,        4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access("err_rd06",  1'b0, 32'h06,        4'hF, 32'h0,         32'h0, 1'b1);
        access("err_wr14",  1'b1, 32'h14,        4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access("err_below", 1'b1, 32'hFFFF_FFFC, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        rd("err_lo",    O_LO,    32'h0000_AB65);
        rd("err_ctrl",  O_CTRL,  32'h0);
        rd("err_cmplo", O_CMPLO, 32'd100);
        rd("err_cmphi", O_CMPHI, 32'h1);

        // Back-to-back read/write/read and CTRL field masking.
        rd("b2b_rd0", O_CMPLO, 32'h0000_0064);
        wr("b2b_wr",  O_CMPLO, 4'b1100, 32'h1234_5678);
        rd("b2b_rd1", O_CMPLO, 32'h1234_0064);
        wr("ctrl_mask", O_CTRL, 4'hF, 32'hFFFF_FF00);
        rd("ctrl_mask_rd", O_CTRL, 32'h0000_FF00);
        wr("be0_noop", O_CMPHI, 4'h0, 32'hFFFF_FFFF);
        rd("be0_rd", O_CMPHI, 32'h1);
        wr("ctrl_clean", O_CTRL, 4'hF, 32'h0);
        check("irq_low_end", 64'(timer_irq_o), 64'd0);

        // Reset with a response in flight.
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = BASE + O_LO;
        be_i   = 4'hF;
        @(posedge clk_i);
        #1;
        req_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("rst_drop_rvalid", 64'(rvalid_o), 64'd0);
        idle(1);
        rst_ni = 1'b1;
        idle(1);
        rd("post_rst_cmplo", O_CMPLO, 32'hFFFF_FFFF);
        rd("post_rst_lo",    O_LO,    32'h0);
        rd("post_rst_ctrl",  O_CTRL,  32'h0);

        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
